// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and parameter defaults.
package period_meter_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-flop
// edge detector that emits single-cycle rise/fall pulses.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures the period and high time of an asynchronous signal in clk cycles,
// one measurement per start request, with saturation on timeout.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow,
  output state_e           state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic rise, fall;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (sig_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_stage_q, high_stage_d;
  logic             seen_fall_q, seen_fall_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      high_stage_q <= '0;
      seen_fall_q  <= 1'b0;
      period_q     <= '0;
      high_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_stage_q <= high_stage_d;
      seen_fall_q  <= seen_fall_d;
      period_q     <= period_d;
      high_q       <= high_d;
      ovf_q        <= ovf_d;
    end
  end

  // Published results only change on the edge that enters DONE, so they are
  // stable everywhere except at the start of the valid cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_stage_d = high_stage_q;
    seen_fall_d  = seen_fall_q;
    period_d     = period_q;
    high_d       = high_q;
    ovf_d        = ovf_q;
    busy         = 1'b0;
    valid        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ARM;
          cnt_d        = '0;
          high_stage_d = '0;
          seen_fall_d  = 1'b0;
        end
      end
      ST_ARM: begin
        busy = 1'b1;
        if (cnt_q == CNT_MAX) begin
          ovf_d    = 1'b1;
          period_d = CNT_MAX;
          high_d   = CNT_MAX;
          state_d  = ST_DONE;
        end else if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_MEASURE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_MEASURE: begin
        busy = 1'b1;
        if (cnt_q == CNT_MAX) begin
          ovf_d    = 1'b1;
          period_d = CNT_MAX;
          high_d   = CNT_MAX;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall) begin
            high_stage_d = cnt_q;
            seen_fall_d  = 1'b1;
          end
          if (rise) begin
            period_d = cnt_q;
            high_d   = seen_fall_q ? high_stage_q : cnt_q;
            ovf_d    = 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        valid   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign overflow  = ovf_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_period_meter.sv
// Randomized scoreboard bench for period_meter: stimulus pushes the expected
// {overflow, period, high_time} derived from the waveform it drives.
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int W     = 2 * CNT_W + 1;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             overflow;
  state_e           dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held = '0;
  int total = 0;
  int bad   = 0;

  period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .start     (start),
    .busy      (busy),
    .valid     (valid),
    .period    (period),
    .high_time (high_time),
    .overflow  (overflow),
    .state_o   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit ovf, input int per, input int hi);
    logic [CNT_W-1:0] p, h;
    p = per[CNT_W-1:0];
    h = hi[CNT_W-1:0];
    return {ovf, p, h};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {overflow, period, high_time};
    if (rst) begin
      held = '0;
    end else if (valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid got=%h at %0t", got, $time);
      end else begin
        e = exp_q.pop_front();
        check("result", got, e);
        check("busy_at_valid", W'(busy), W'(0));
        held = e;
      end
    end else begin
      check("hold", got, held);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Two full periods of hi cycles high then lo cycles low after arming.
  task automatic measure(input int hi, input int lo, input bit dup_start);
    sig_in = 1'b0;
    repeat (SYNC + 3) step();
    pulse_start();
    exp_q.push_back(pack(1'b0, hi + lo, hi));
    repeat (2) step();
    for (int k = 0; k < 2; k++) begin
      sig_in = 1'b1;
      for (int c = 0; c < hi; c++) begin
        start = (dup_start && k == 0 && c == 0);
        step();
      end
      start  = 1'b0;
      sig_in = 1'b0;
      repeat (lo) step();
    end
    wait_drain(100);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    check("rst_busy",   W'(busy),     W'(0));
    check("rst_valid",  W'(valid),    W'(0));
    check("rst_period", W'(period),   W'(0));
    check("rst_high",   W'(high_time), W'(0));
    check("rst_ovf",    W'(overflow), W'(0));
    rst = 1'b0;
    step();

    measure(5, 5, 1'b0);
    measure(3, 7, 1'b0);
    for (int p = 1; p <= 4; p++) measure(p, p, 1'b0);

    // timeout with sig_in stuck low
    sig_in = 1'b0;
    repeat (SYNC + 3) step();
    pulse_start();
    exp_q.push_back(pack(1'b1, MAXV, MAXV));
    wait_drain(400);

    // second start while busy must be ignored
    measure(5, 5, 1'b1);
    measure(6, 3, 1'b0);

    // reset in the middle of MEASURE aborts without a valid
    sig_in = 1'b0;
    repeat (SYNC + 3) step();
    pulse_start();
    repeat (2) step();
    sig_in = 1'b1;
    repeat (5) step();
    sig_in = 1'b0;
    repeat (4) step();
    check("busy_before_rst", W'(busy), W'(1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_busy",   W'(busy),      W'(0));
    check("midrst_valid",  W'(valid),     W'(0));
    check("midrst_period", W'(period),    W'(0));
    check("midrst_high",   W'(high_time), W'(0));
    check("midrst_ovf",    W'(overflow),  W'(0));
    repeat (3) step();
    rst = 1'b0;
    step();
    measure(4, 6, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int hi, lo;
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 12);
      measure(hi, lo, ($urandom_range(0, 3) == 0));
    end

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
